// File: rtl/fifo_wr_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// No logic; constants and the two-state FSM encoding only.
// Backpressure: not applicable.
package fifo_wr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DW_DEF        = 8;
    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when req is all zeros.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             found,
    output logic [IW-1:0]    index
);

    // Walk offsets 1..N_REQ so the previous holder is considered last.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        index = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last) + k) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N_REQ writers onto one FIFO write port in round-robin bursts of up to BURST_MAX.
// Latency: one bubble cycle per grant, then data passes combinationally to w_data/wd_en.
// Backpressure: full holds the grant with req_ready low and the beat count frozen.
module fifo_wr_arbiter
    import fifo_wr_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                w_clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                full,
    output logic                wd_en,
    output logic [DW-1:0]       w_data,
    output logic [IW-1:0]       gnt_id,
    output logic                busy
);

    // Beat counter only ever holds 0..BURST_MAX-1; leaving BURST clears it.
    localparam int             BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_MAX - 1);

    state_t         state;
    logic [IW-1:0]  gnt_q;
    logic [IW-1:0]  last_q;
    logic [BW-1:0]  beat_q;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           in_burst;
    logic           gnt_valid;
    logic           xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_q),
        .found (pick_found),
        .index (pick_idx)
    );

    // Output decode; rst masks everything so a reset cycle never writes.
    always_comb begin
        in_burst  = (state == BURST) && !rst;
        gnt_valid = req_valid[gnt_q];
        xfer      = in_burst && gnt_valid && !full;
        req_ready = '0;
        if (in_burst) begin
            req_ready[gnt_q] = ~full;
        end
        wd_en  = xfer;
        w_data = req_data[int'(gnt_q)*DW +: DW];
        busy   = in_burst;
        gnt_id = rst ? '0 : gnt_q;
    end

    // Grant FSM: pick in IDLE, stream in BURST until the limit or the holder goes idle.
    always_ff @(posedge w_clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            last_q <= IW'(N_REQ - 1);
            beat_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q <= pick_idx;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (!gnt_valid || (xfer && beat_q == LAST_BEAT)) begin
                        state  <= IDLE;
                        beat_q <= '0;
                        last_q <= gnt_q;
                    end else if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboarded checks of fifo_wr_arbiter with default parameters.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// Every comparison goes through check().
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic            w_clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            full;
    logic            wd_en;
    logic [DW-1:0]   w_data;
    logic [1:0]      gnt_id;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .BURST_MAX (BM)
    ) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wd_en     (wd_en),
        .w_data    (w_data),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic f);
        @(negedge w_clk);
        rst       = r;
        req_valid = v;
        full      = f;
    endtask

    // Sample and compare the control outputs of the current cycle; egnt<0 skips gnt_id.
    task automatic cyc(input string tag, input logic ewd, input logic ebusy,
                       input logic [N-1:0] erdy, input int egnt);
        #1;
        check({tag, ".wd_en"},     32'(wd_en),     32'(ewd));
        check({tag, ".busy"},      32'(busy),      32'(ebusy));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(erdy));
        if (egnt >= 0) check({tag, ".gnt_id"}, 32'(gnt_id), 32'(egnt));
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        drive(1'b1, v, 1'b0);
        cyc("reset0", 1'b0, 1'b0, '0, 0);
        drive(1'b1, v, 1'b0);
        cyc("reset1", 1'b0, 1'b0, '0, 0);
    endtask

    logic [5:0]   seq [N];
    logic [N-1:0] hs;
    int           g;
    int           who;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;

        // All requesters valid, even during reset: nothing may be written.
        do_reset('1);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);

        // Continuous traffic: grants 0,1,2,3,0, four beats each, one bubble between.
        for (int k = 0; k < 5; k++) begin
            g = k % N;
            drive(1'b0, '1, 1'b0);
            cyc("rr_bubble", 1'b0, 1'b0, '0, -1);
            for (int b = 0; b < BM; b++) begin
                drive(1'b0, '1, 1'b0);
                cyc("rr_beat", 1'b1, 1'b1, N'(1 << g), g);
                check("rr_data", 32'(w_data), 32'(8'h10 + 8'(g)));
            end
        end

        // Requester 2 alone: two words then drop; next grant must be 3 (last_gnt=2).
        do_reset('0);
        req_data[2*DW +: DW] = 8'hA1;
        drive(1'b0, 4'b0100, 1'b0);
        cyc("one_bubble", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b0100, 1'b0);
        cyc("one_b1", 1'b1, 1'b1, 4'b0100, 2);
        check("one_d1", 32'(w_data), 32'h0A1);
        drive(1'b0, 4'b0100, 1'b0);
        req_data[2*DW +: DW] = 8'hA2;
        cyc("one_b2", 1'b1, 1'b1, 4'b0100, 2);
        check("one_d2", 32'(w_data), 32'h0A2);
        drive(1'b0, 4'b0000, 1'b0);
        cyc("one_drop", 1'b0, 1'b1, 4'b0100, 2);
        drive(1'b0, 4'b1111, 1'b0);
        cyc("one_idle", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b1111, 1'b0);
        cyc("one_next", 1'b1, 1'b1, 4'b1000, 3);

        // full for 5 cycles after first beat: hold, then exactly 3 more beats.
        do_reset('0);
        drive(1'b0, 4'b0010, 1'b0);
        cyc("full_bubble", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b0010, 1'b0);
        cyc("full_b1", 1'b1, 1'b1, 4'b0010, 1);
        repeat (5) begin
            drive(1'b0, 4'b0010, 1'b1);
            cyc("full_hold", 1'b0, 1'b1, '0, 1);
        end
        repeat (3) begin
            drive(1'b0, 4'b0010, 1'b0);
            cyc("full_rest", 1'b1, 1'b1, 4'b0010, 1);
        end
        drive(1'b0, 4'b0010, 1'b0);
        cyc("full_end", 1'b0, 1'b0, '0, -1);

        // Reset on the second beat of a requester-1 burst; afterwards requester 0 first.
        do_reset('0);
        drive(1'b0, 4'b0010, 1'b0);
        cyc("rb_bubble", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b0010, 1'b0);
        cyc("rb_b1", 1'b1, 1'b1, 4'b0010, 1);
        drive(1'b1, 4'b0011, 1'b0);
        cyc("rb_rst", 1'b0, 1'b0, '0, 0);
        drive(1'b0, 4'b0011, 1'b0);
        cyc("rb_after", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b0011, 1'b0);
        cyc("rb_first", 1'b1, 1'b1, 4'b0001, 0);

        // Requester 3 drops valid while full: back to IDLE with no write, then grant 0.
        do_reset('0);
        drive(1'b0, 4'b1000, 1'b0);
        cyc("drop_bubble", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b1000, 1'b1);
        cyc("drop_full", 1'b0, 1'b1, '0, 3);
        drive(1'b0, 4'b0001, 1'b1);
        cyc("drop_now", 1'b0, 1'b1, '0, 3);
        drive(1'b0, 4'b0001, 1'b0);
        cyc("drop_idle", 1'b0, 1'b0, '0, -1);
        drive(1'b0, 4'b0001, 1'b0);
        cyc("drop_next", 1'b1, 1'b1, 4'b0001, 0);

        // Random valid/full traffic: each handshake must write that requester's next word.
        do_reset('0);
        for (int i = 0; i < N; i++) seq[i] = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge w_clk);
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_data[i*DW +: DW] = {2'(i), seq[i]};
            end
            full = ($urandom_range(0, 4) == 0);
            #1;
            hs = req_valid & req_ready;
            check("sb_rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
            check("sb_wd_hs", 32'(wd_en), 32'(hs != '0));
            if (hs != '0) begin
                who = 0;
                for (int i = 0; i < N; i++) if (hs[i]) who = i;
                check("sb_data", 32'(w_data), 32'({2'(who), seq[who]}));
                seq[who] = seq[who] + 6'd1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
